// File: rtl/send_to_arduino_if.sv
// Word handshake between a telemetry producer and the Arduino serial link.
// The producer offers data/dataValid; the transmitter answers with dataReady.
interface send_to_arduino_if;
    logic [15:0] data;
    logic        dataValid;
    logic        dataReady;

    modport master (
        output data,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  data,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/send_to_arduino.sv
// 8N1 serial transmitter: one 16-bit word per handshake, sent as an optional
// sync byte followed by the high and low data bytes.
module send_to_arduino #(
    parameter int         CLKS_PER_BIT = 1736,
    parameter bit         USE_HEADER   = 1'b1,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    send_to_arduino_if.slave  link,
    output logic              serialToArduino,
    output logic              busy,
    output logic              txDone
);
    localparam int BW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] LAST_BYTE = USE_HEADER ? 2'd2 : 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    txState_t      state;
    txState_t      stateNext;
    logic [BW-1:0] baudCnt;
    logic [BW-1:0] baudNext;
    logic [2:0]    bitCnt;
    logic [2:0]    bitNext;
    logic [1:0]    byteIdx;
    logic [1:0]    byteNext;
    logic [7:0]    shiftReg;
    logic [7:0]    shiftNext;
    logic [15:0]   holdReg;
    logic [15:0]   holdNext;
    logic          lineReg;
    logic          lineNext;
    logic          bitEnd;

    function automatic logic [7:0] pickByte(
        input logic [1:0]  idx,
        input logic [15:0] word
    );
        logic [7:0] b;
        if (USE_HEADER) begin
            case (idx)
                2'd0:    b = HEADER_BYTE;
                2'd1:    b = word[15:8];
                default: b = word[7:0];
            endcase
        end else begin
            b = (idx == 2'd0) ? word[15:8] : word[7:0];
        end
        return b;
    endfunction

    assign bitEnd          = (baudCnt == BAUD_LAST);
    assign link.dataReady  = (state == IDLE);
    assign busy            = (state != IDLE);
    assign serialToArduino = lineReg;

    // lineNext is the level for the coming cycle, so the pin comes from a flop.
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitCnt;
        byteNext  = byteIdx;
        shiftNext = shiftReg;
        holdNext  = holdReg;
        lineNext  = lineReg;
        txDone    = 1'b0;

        if (state != IDLE) begin
            baudNext = bitEnd ? '0 : baudCnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                lineNext = 1'b1;
                if (link.dataValid) begin
                    holdNext  = link.data;
                    shiftNext = pickByte(2'd0, link.data);
                    byteNext  = 2'd0;
                    bitNext   = 3'd0;
                    baudNext  = '0;
                    lineNext  = 1'b0;
                    stateNext = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    lineNext  = shiftReg[0];
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext = {1'b0, shiftReg[7:1]};
                    bitNext   = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        lineNext  = 1'b1;
                        stateNext = STOP;
                    end else begin
                        lineNext = shiftReg[1];
                    end
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (byteIdx == LAST_BYTE) begin
                        txDone    = 1'b1;
                        lineNext  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        byteNext  = byteIdx + 2'd1;
                        shiftNext = pickByte(byteIdx + 2'd1, holdReg);
                        bitNext   = 3'd0;
                        lineNext  = 1'b0;
                        stateNext = START;
                    end
                end
            end
            default: begin
                lineNext  = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitCnt   <= 3'd0;
            byteIdx  <= 2'd0;
            shiftReg <= 8'd0;
            holdReg  <= 16'd0;
            lineReg  <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitCnt   <= bitNext;
            byteIdx  <= byteNext;
            shiftReg <= shiftNext;
            holdReg  <= holdNext;
            lineReg  <= lineNext;
        end
    end
endmodule

// File: tb/tb_send_to_arduino.sv
// Bench for send_to_arduino: a UART decoder on the selected line pops
// expected bytes queued when each word is offered.
module tb_send_to_arduino;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int rstCnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) rstCnt <= rstCnt + 1;

    int nChecks = 0;
    int nErrors = 0;
    int sel = 0;
    int cpb = 4;
    logic [15:0] tbData = 16'h0;
    logic        tbValid = 1'b0;

    logic [7:0] expQ[$];
    int         startQ[$];

    send_to_arduino_if if0();
    send_to_arduino_if if1();
    send_to_arduino_if if2();

    logic line0, line1, line2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;

    assign if0.data = tbData;
    assign if1.data = tbData;
    assign if2.data = tbData;
    assign if0.dataValid = tbValid && (sel == 0);
    assign if1.dataValid = tbValid && (sel == 1);
    assign if2.dataValid = tbValid && (sel == 2);

    send_to_arduino #(
        .CLKS_PER_BIT(4), .USE_HEADER(1'b1), .HEADER_BYTE(8'hA5)
    ) u0 (
        .clk(clk), .rst(rst), .link(if0),
        .serialToArduino(line0), .busy(busy0), .txDone(done0)
    );

    send_to_arduino #(
        .CLKS_PER_BIT(4), .USE_HEADER(1'b0), .HEADER_BYTE(8'hA5)
    ) u1 (
        .clk(clk), .rst(rst), .link(if1),
        .serialToArduino(line1), .busy(busy1), .txDone(done1)
    );

    send_to_arduino u2 (
        .clk(clk), .rst(rst), .link(if2),
        .serialToArduino(line2), .busy(busy2), .txDone(done2)
    );

    logic mon, readySel, busySel, doneSel;
    assign mon      = (sel == 0) ? line0 : (sel == 1) ? line1 : line2;
    assign busySel  = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    assign doneSel  = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    assign readySel = (sel == 0) ? if0.dataReady :
                      (sel == 1) ? if1.dataReady : if2.dataReady;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    int doneCnt = 0;
    int lastDone = -1;
    always @(negedge clk) begin
        if (doneSel === 1'b1) begin
            doneCnt++;
            lastDone = cyc;
        end
    end

    // Decoder: samples every cycle of every bit so a stretched or
    // shortened bit shows up as an unstable frame.
    initial begin : decoder
        logic [7:0] b;
        bit ok;
        logic v;
        int s, r0, bits;
        forever begin
            @(negedge clk);
            if (mon === 1'b0) begin
                s = cyc;
                ok = 1'b1;
                r0 = rstCnt;
                bits = cpb;
                for (int i = 1; i < bits; i++) begin
                    @(negedge clk);
                    if (mon !== 1'b0) ok = 1'b0;
                end
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    v = mon;
                    for (int i = 1; i < bits; i++) begin
                        @(negedge clk);
                        if (mon !== v) ok = 1'b0;
                    end
                    b[k] = v;
                end
                for (int i = 0; i < bits; i++) begin
                    @(negedge clk);
                    if (mon !== 1'b1) ok = 1'b0;
                end
                if (rstCnt == r0) begin
                    startQ.push_back(s);
                    check("frame", int'(ok), 1);
                    if (expQ.size() == 0) check("sb_pending", expQ.size(), 1);
                    else check("byte", int'(b), int'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input bit keep, output int acc);
        int n = 0;
        tbData = w;
        tbValid = 1'b1;
        if (sel != 1) expQ.push_back(8'hA5);
        expQ.push_back(w[15:8]);
        expQ.push_back(w[7:0]);
        while (readySel !== 1'b1 && n < 100000) begin
            @(negedge clk);
            n++;
        end
        check("accept", int'(readySel), 1);
        acc = cyc;
        @(negedge clk);
        if (!keep) tbValid = 1'b0;
    endtask

    task automatic waitDone(input int d0, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (doneCnt > d0) break;
        end
        check("done_seen", int'(doneCnt > d0), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int acc, acc2, bad, d0, n;

        repeat (3) @(negedge clk);
        check("rst_line", int'(line0), 1);
        check("rst_ready", int'(if0.dataReady), 1);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_line_long", int'(line2), 1);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (line0 !== 1'b1 || if0.dataReady !== 1'b1 || busy0 !== 1'b0)
                bad++;
        end
        check("idle_stable", bad, 0);

        // header packet, 4 clocks per bit
        sel = 0; cpb = 4;
        startQ.delete();
        d0 = doneCnt;
        send(16'h12C3, 1'b0, acc);
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            if (busySel !== 1'b1) bad++;
            @(negedge clk);
        end
        check("busy_hold", bad, 0);
        waitDone(d0, 200);
        check("hdr_bytes", startQ.size(), 3);
        if (startQ.size() > 0) begin
            check("start_lat", startQ[0] - acc, 1);
            check("pkt_len", lastDone + 1 - startQ[0], 120);
        end
        check("done_once", doneCnt - d0, 1);
        check("sb_drained", expQ.size(), 0);

        // back-to-back, no header
        sel = 1; cpb = 4;
        startQ.delete();
        d0 = doneCnt;
        send(16'hFF00, 1'b1, acc);
        send(16'h0001, 1'b0, acc2);
        check("b2b_accept", acc2 - lastDone, 1);
        waitDone(d0 + 1, 200);
        check("b2b_bytes", startQ.size(), 4);
        if (startQ.size() >= 4)
            check("line_gap", startQ[2] - startQ[1] - 40, 1);
        check("b2b_done", doneCnt - d0, 2);
        check("sb_drained", expQ.size(), 0);

        // data changes while in flight
        d0 = doneCnt;
        send(16'h00B4, 1'b0, acc);
        repeat (15) @(negedge clk);
        tbData = 16'hBEEF;
        waitDone(d0, 200);
        check("chg_done", doneCnt - d0, 1);
        check("sb_drained", expQ.size(), 0);

        // reset during the second byte's data bits
        send(16'h3C5A, 1'b0, acc);
        repeat (50) @(negedge clk);
        d0 = doneCnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_line", int'(line1), 1);
        check("abort_ready", int'(if1.dataReady), 1);
        check("abort_busy", int'(busy1), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("abort_no_done", doneCnt - d0, 0);
        check("abort_sb", expQ.size(), 1);
        expQ.delete();
        d0 = doneCnt;
        send(16'h0005, 1'b0, acc);
        waitDone(d0, 200);
        check("sb_drained", expQ.size(), 0);

        // default baud rate
        sel = 2; cpb = 1736;
        startQ.delete();
        d0 = doneCnt;
        send(16'h0168, 1'b0, acc);
        n = 0;
        while (mon === 1'b0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("bit_period", n, 1736);
        waitDone(d0, 60000);
        check("long_bytes", startQ.size(), 3);
        if (startQ.size() > 0)
            check("long_pkt_len", lastDone + 1 - startQ[0], 52080);
        check("sb_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end
endmodule
